// File: rtl/mode_ctrl_if.sv
// Key/timebase inputs and control outputs of the clock user-interface sequencer.
//   key_val   : debounced one-cycle key strobe (0 none, 1 MODE, 2 SET, 3 UP, 4 DOWN)
//   tick_1hz  : one-cycle 1 Hz pulse
//   disp_mode, set_field, clk_hold, inc_pulse, dec_pulse,
//   alm_en, sw_run, sw_clr, blink_on : sequencer outputs
// master drives keys/ticks and observes outputs; slave is the sequencer.
interface mode_ctrl_if;
  logic [2:0] key_val;
  logic       tick_1hz;
  logic [1:0] disp_mode;
  logic [1:0] set_field;
  logic       clk_hold;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       alm_en;
  logic       sw_run;
  logic       sw_clr;
  logic       blink_on;

  modport master (
    output key_val, tick_1hz,
    input  disp_mode, set_field, clk_hold, inc_pulse, dec_pulse,
           alm_en, sw_run, sw_clr, blink_on
  );

  modport slave (
    input  key_val, tick_1hz,
    output disp_mode, set_field, clk_hold, inc_pulse, dec_pulse,
           alm_en, sw_run, sw_clr, blink_on
  );
endinterface

// File: rtl/mode_ctrl.sv
// Clock user-interface sequencer: walks display modes and set fields from key
// strobes, drives counter hold/inc/dec/stopwatch controls, blinks the edited
// digits and leaves set mode after TIMEOUT_S idle seconds.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : mode_ctrl_if.slave (key_val/tick_1hz in, all control outputs out)
// All outputs are registered; responses appear the cycle after the key strobe.
module mode_ctrl #(
  parameter int unsigned BLINK_HALF = 25_000_000,
  parameter int unsigned TIMEOUT_S  = 10
) (
  input logic        clk,
  input logic        rst,
  mode_ctrl_if.slave bus
);

  localparam int unsigned BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned TCW = 6;

  localparam logic [2:0] CLK_RUN   = 3'd0;
  localparam logic [2:0] CLK_SET_H = 3'd1;
  localparam logic [2:0] CLK_SET_M = 3'd2;
  localparam logic [2:0] CLK_SET_S = 3'd3;
  localparam logic [2:0] ALM_VIEW  = 3'd4;
  localparam logic [2:0] ALM_SET_H = 3'd5;
  localparam logic [2:0] ALM_SET_M = 3'd6;
  localparam logic [2:0] SW_VIEW   = 3'd7;

  localparam logic [2:0] KEY_MODE = 3'd1;
  localparam logic [2:0] KEY_SET  = 3'd2;
  localparam logic [2:0] KEY_UP   = 3'd3;
  localparam logic [2:0] KEY_DOWN = 3'd4;

  function automatic logic is_set(input logic [2:0] s);
    return (s inside {CLK_SET_H, CLK_SET_M, CLK_SET_S, ALM_SET_H, ALM_SET_M});
  endfunction

  function automatic logic [1:0] field_of(input logic [2:0] s);
    case (s)
      CLK_SET_H, ALM_SET_H: return 2'd1;
      CLK_SET_M, ALM_SET_M: return 2'd2;
      CLK_SET_S:            return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] disp_of(input logic [2:0] s);
    if (s == SW_VIEW) return 2'd2;
    if (s[2])         return 2'd1;
    return 2'd0;
  endfunction

  // Set states exit to the view of their own mode group
  function automatic logic [2:0] view_of(input logic [2:0] s);
    return s[2] ? ALM_VIEW : CLK_RUN;
  endfunction

  function automatic logic [2:0] next_field(input logic [2:0] s);
    case (s)
      CLK_SET_H: return CLK_SET_M;
      CLK_SET_M: return CLK_SET_S;
      ALM_SET_H: return ALM_SET_M;
      default:   return view_of(s);
    endcase
  endfunction

  logic [2:0]     state_q, state_d;
  logic [1:0]     disp_q, disp_d;
  logic [1:0]     field_q, field_d;
  logic           hold_q, hold_d;
  logic           inc_q, inc_d;
  logic           dec_q, dec_d;
  logic           alm_q, alm_d;
  logic           run_q, run_d;
  logic           clr_q, clr_d;
  logic           blink_q, blink_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           key_ok;
  logic           expire;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLK_RUN;
      disp_q  <= 2'd0;
      field_q <= 2'd0;
      hold_q  <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      alm_q   <= 1'b0;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      blink_q <= 1'b1;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      field_q <= field_d;
      hold_q  <= hold_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      alm_q   <= alm_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next state, strobes, blink and timeout
  always_comb begin
    state_d = state_q;
    alm_d   = alm_q;
    run_d   = run_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    clr_d   = 1'b0;
    blink_d = 1'b1;
    bcnt_d  = '0;
    tcnt_d  = '0;

    key_ok = (bus.key_val inside {KEY_MODE, KEY_SET, KEY_UP, KEY_DOWN});
    expire = is_set(state_q) && (tcnt_q == TCW'(TIMEOUT_S));

    if (key_ok) begin
      if (is_set(state_q)) begin
        case (bus.key_val)
          KEY_MODE: state_d = view_of(state_q);
          KEY_SET:  state_d = next_field(state_q);
          KEY_UP:   inc_d   = 1'b1;
          default:  dec_d   = 1'b1;
        endcase
      end else begin
        case (state_q)
          CLK_RUN: begin
            if (bus.key_val == KEY_MODE) state_d = ALM_VIEW;
            if (bus.key_val == KEY_SET)  state_d = CLK_SET_H;
          end
          ALM_VIEW: begin
            if (bus.key_val == KEY_MODE) state_d = SW_VIEW;
            if (bus.key_val == KEY_SET)  state_d = ALM_SET_H;
            if (bus.key_val == KEY_UP)   alm_d   = !alm_q;
          end
          default: begin
            if (bus.key_val == KEY_MODE) state_d = CLK_RUN;
            if (bus.key_val == KEY_SET)  run_d   = !run_q;
            if (bus.key_val == KEY_UP && !run_q) clr_d = 1'b1;
          end
        endcase
      end
    end else if (expire) begin
      state_d = view_of(state_q);
    end

    // Blink restarts visible on field entry/change and on every adjustment
    if (is_set(state_d) && state_d == state_q && !inc_d && !dec_d) begin
      if (bcnt_q == BCW'(BLINK_HALF - 1)) begin
        blink_d = !blink_q;
      end else begin
        blink_d = blink_q;
        bcnt_d  = BCW'(bcnt_q + 1'b1);
      end
    end

    // Idle-second counter only runs while staying in set mode without keys
    if (is_set(state_d) && is_set(state_q) && !key_ok) begin
      tcnt_d = bus.tick_1hz ? TCW'(tcnt_q + 1'b1) : tcnt_q;
    end

    disp_d  = disp_of(state_d);
    field_d = field_of(state_d);
    hold_d  = is_set(state_d) && !state_d[2];
  end

  assign bus.disp_mode = disp_q;
  assign bus.set_field = field_q;
  assign bus.clk_hold  = hold_q;
  assign bus.inc_pulse = inc_q;
  assign bus.dec_pulse = dec_q;
  assign bus.alm_en    = alm_q;
  assign bus.sw_run    = run_q;
  assign bus.sw_clr    = clr_q;
  assign bus.blink_on  = blink_q;

endmodule
